// File: rtl/elastic_fifo.sv
// elastic_fifo: valid/ready token FIFO with NUM_SLOTS entries (any count 1..64).
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset; clears pointers and occupancy
//   ins         upstream token data
//   ins_valid   upstream token present
//   ins_ready   FIFO can accept a token this cycle (not full)
//   outs        head token data
//   outs_valid  head token present
//   outs_ready  downstream accepts the head token this cycle
//
// Configuration
//   ELASTIC_FIFO_BYPASS_EN  when defined, an empty FIFO is transparent: ins and
//                           ins_valid drive outs and outs_valid combinationally,
//                           and a token taken downstream in the same cycle is
//                           never stored. Undefined (default), the minimum
//                           latency is one cycle and there is no path from the
//                           input side to the output side.
module elastic_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int unsigned CNT_W = $clog2(NUM_SLOTS + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] storage [NUM_SLOTS];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;

  logic empty;
  logic full;
  logic enq;
  logic deq;

  // Pointer advance with explicit wrap, valid for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Ready is a pure decode of occupancy; held high while in reset.
  assign ins_ready = rst | ~full;

`ifdef ELASTIC_FIFO_BYPASS_EN
  // Empty FIFO forwards the input side; a token consumed on the spot is not stored.
  logic pass;

  assign outs_valid = ~rst & (empty ? ins_valid : 1'b1);
  assign outs       = empty ? ins : storage[head];
  assign pass       = empty & ins_valid & outs_ready;
  assign deq        = ~rst & ~empty & outs_ready;
  assign enq        = ~rst & ins_valid & ~full & ~pass;
`else
  assign outs_valid = ~rst & ~empty;
  assign outs       = storage[head];
  assign deq        = outs_valid & outs_ready;
  assign enq        = ~rst & ins_valid & ~full;
`endif

  // Pointer and occupancy update; reset discards whatever is stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail <= next_ptr(tail);
      end
      if (deq) begin
        head <= next_ptr(head);
      end
      if (enq && !deq) begin
        count <= count + CNT_W'(1);
      end else if (deq && !enq) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Token storage; contents are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (enq) begin
      storage[tail] <= ins;
    end
  end

endmodule
